// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, control-bit positions and NOP encoding for pipeline stage registers
package pipe_pkg;

  // Per-boundary bundle widths
  localparam int IFID_CTRL_W  = 4;
  localparam int IFID_DATA_W  = 64;   // pc + instruction
  localparam int IDEX_CTRL_W  = 8;
  localparam int IDEX_DATA_W  = 128;  // operands, immediate, register indices, funct
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 112;  // alu result, store data, rd, pc+4
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 72;   // write-back value, rd, pc+4

  // ID/EX control-bundle bit positions
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_RD     = 1;
  localparam int CTRL_MEM_WR     = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_OP_W   = 2;

  // All-zero control is a NOP: nothing writes, nothing touches memory
  localparam logic [IDEX_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - handshake and bundle signals of one elastic stage boundary
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;

  // Stage side
  modport slave (
    input  flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
  );

  // Surrounding pipeline side
  modport master (
    output flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+ctrl+data entry with load and clear
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = IDEX_CTRL_W,
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_d_i,
  input  logic [DATA_W-1:0] data_d_i,
  output logic              v_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              v_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Valid and control: ctrl is reloaded with CTRL_RST on clear so an empty entry reads as a NOP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q    <= 1'b0;
      ctrl_q <= CTRL_RST;
    end else if (clear_i) begin
      v_q    <= 1'b0;
      ctrl_q <= CTRL_RST;
    end else if (load_i) begin
      v_q    <= 1'b1;
      ctrl_q <= ctrl_d_i;
    end
  end

  // Payload is only captured, never reset or cleared
  always_ff @(posedge clk_i) begin
    if (load_i) data_q <= data_d_i;
  end

  assign v_o    = v_q;
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage register with 2-entry skid buffer and flush
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = IDEX_CTRL_W,
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_stage_elastic_if.slave  bus
);
  logic              m_v, s_v;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
  logic [DATA_W-1:0] m_data, s_data, m_data_d;
  logic              m_load, m_clear, s_load, s_clear, m_from_skid;
  logic              accept, emit;

  // in_ready comes straight from the skid valid flop, never from out_ready
  assign accept = bus.in_valid_i & ~s_v;
  assign emit   = m_v & bus.out_ready_i;

  // Entry control: flush first, then fill main, overflow into skid, drain skid into main
  always_comb begin
    m_load      = 1'b0;
    m_clear     = 1'b0;
    s_load      = 1'b0;
    s_clear     = 1'b0;
    m_from_skid = 1'b0;
    if (bus.flush_i) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (!m_v) begin
      m_load = accept;
    end else if (!s_v) begin
      if (accept && emit)  m_load  = 1'b1;
      else if (accept)     s_load  = 1'b1;
      else if (emit)       m_clear = 1'b1;
    end else if (emit) begin
      m_load      = 1'b1;
      m_from_skid = 1'b1;
      s_clear     = 1'b1;
    end
  end

  // Main entry reloads either from upstream or from the skid entry
  always_comb begin
    m_ctrl_d = m_from_skid ? s_ctrl : bus.in_ctrl_i;
    m_data_d = m_from_skid ? s_data : bus.in_data_i;
  end

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_main (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (m_load),
    .clear_i  (m_clear),
    .ctrl_d_i (m_ctrl_d),
    .data_d_i (m_data_d),
    .v_o      (m_v),
    .ctrl_o   (m_ctrl),
    .data_o   (m_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (s_load),
    .clear_i  (s_clear),
    .ctrl_d_i (bus.in_ctrl_i),
    .data_d_i (bus.in_data_i),
    .v_o      (s_v),
    .ctrl_o   (s_ctrl),
    .data_o   (s_data)
  );

  assign bus.in_ready_o  = ~s_v;
  assign bus.out_valid_o = m_v;
  assign bus.out_ctrl_o  = m_ctrl;
  assign bus.out_data_o  = m_data;
  assign bus.occupancy_o = {1'b0, m_v} + {1'b0, s_v};

  // The skid entry may only be occupied behind a valid main entry
  a_skid_implies_main: assert property (@(posedge clk_i) disable iff (rst_i) s_v |-> m_v);
endmodule
